// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and defaults for the data-memory arbiter
// Purpose: response-source and FSM state encodings, plus the address/data
//          widths shared with the MEM stage and the RAM wrapper.
// Ports:   none (package).
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 14;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CPU  = 2'd1,
    SRC_DBG  = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_FORCE  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data RAM arbiter between CPU MEM stage and debug port
// Purpose: grants at most one RAM access per cycle. The CPU has priority, a
//          starvation counter forces a debug grant after STARVE_MAX denied
//          cycles, and dbg_lock gives the debug port exclusive ownership.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata     CPU MEM-stage request
//   cpu_stall                 CPU request not issued this cycle
//   cpu_rvalid/rdata          CPU load response (one cycle after grant)
//   dbg_valid/lock/we/addr/wdata  debug request (held until dbg_ready)
//   dbg_ready                 debug request accepted this cycle
//   dbg_rvalid/rdata          debug read response
//   ram_en/we/addr/wdata      RAM command (combinational mux of the winner)
//   ram_rdata                 RAM read data, one-cycle latency
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_valid,
  input  logic              dbg_lock,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);
  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_MAX - 1);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  src_e       resp_q, resp_d;
  src_e       grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
      resp_q   <= SRC_NONE;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      resp_q   <= resp_d;
    end
  end

  // Grant selection and next state. Grants are suppressed while rst is high
  // so the RAM sees no command during reset.
  always_comb begin
    grant   = SRC_NONE;
    state_d = state_q;
    if (!rst) begin
      if (state_q == ST_FORCE) begin
        if (dbg_valid) begin
          grant   = SRC_DBG;
          state_d = dbg_lock ? ST_LOCKED : ST_NORMAL;
        end else begin
          // Debug withdrew: do not hold the CPU hostage for a vanished request.
          if (cpu_req) grant = SRC_CPU;
          state_d = ST_NORMAL;
        end
      end else if (state_q == ST_LOCKED && dbg_lock) begin
        if (dbg_valid) grant = SRC_DBG;
      end else begin
        // NORMAL, or the cycle dbg_lock drops (already arbitrated as NORMAL).
        state_d = ST_NORMAL;
        if (cpu_req)        grant = SRC_CPU;
        else if (dbg_valid) grant = SRC_DBG;
        if (grant == SRC_DBG && dbg_lock)
          state_d = ST_LOCKED;
        else if (cpu_req && dbg_valid && starve_q >= STARVE_LIM_C)
          state_d = ST_FORCE;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!dbg_valid || grant == SRC_DBG)
      starve_d = '0;
    else if (starve_q < STARVE_MAX_C)
      starve_d = starve_q + 4'd1;
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (grant)
      SRC_CPU: begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      SRC_DBG: begin
        ram_en    = 1'b1;
        ram_we    = dbg_we;
        ram_addr  = dbg_addr;
        ram_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  // Remember who issued a read so the returning data is steered to them.
  always_comb begin
    resp_d = SRC_NONE;
    if (ram_en && !ram_we) resp_d = grant;
  end

  assign cpu_stall  = cpu_req && (grant != SRC_CPU) && !rst;
  assign dbg_ready  = (grant == SRC_DBG);
  assign cpu_rvalid = (resp_q == SRC_CPU);
  assign dbg_rvalid = (resp_q == SRC_DBG);
  assign cpu_rdata  = ram_rdata;
  assign dbg_rdata  = ram_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a 16K x 32 RAM model
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        cpu_req, cpu_we, dbg_valid, dbg_lock, dbg_we;
  logic [13:0] cpu_addr, dbg_addr, ram_addr;
  logic [31:0] cpu_wdata, dbg_wdata, ram_wdata, ram_rdata, cpu_rdata, dbg_rdata;
  logic        cpu_stall, cpu_rvalid, dbg_ready, dbg_rvalid, ram_en, ram_we;

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_valid(dbg_valid), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dbg_q[$];
  logic [31:0] mem    [0:16383];
  logic [31:0] shadow [0:16383];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] init_word(input logic [13:0] a);
    if (a == 14'h10) return 32'hDEADBEEF;
    return {18'h2B6A5, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous read, one-cycle latency.
  initial begin
    ram_rdata = '0;
    for (int i = 0; i < 16384; i++) mem[i] = init_word(14'(i));
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) mem[ram_addr] = ram_wdata;
        else        ram_rdata = mem[ram_addr];
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (cpu_rvalid && dbg_rvalid) check("both_rvalid", 32'(dbg_rvalid), 32'd0);
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      check("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      check("cpu_rdata", cpu_rdata, cpu_q[0].data);
      void'(cpu_q.pop_front());
    end else if (cpu_rvalid) begin
      check("cpu_spurious_rvalid", 32'(cpu_rvalid), 32'd0);
    end
    if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
      check("dbg_rvalid", 32'(dbg_rvalid), 32'd1);
      check("dbg_rdata", dbg_rdata, dbg_q[0].data);
      void'(dbg_q.pop_front());
    end else if (dbg_rvalid) begin
      check("dbg_spurious_rvalid", 32'(dbg_rvalid), 32'd0);
    end
  end

  task automatic apply(input string tag,
                       input logic c_req, input logic c_we, input logic [13:0] c_addr,
                       input logic [31:0] c_wd,
                       input logic d_val, input logic d_lock, input logic d_we,
                       input logic [13:0] d_addr, input logic [31:0] d_wd,
                       input logic exp_cpu, input logic exp_dbg);
    exp_t e;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_valid = d_val; dbg_lock = d_lock; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    if (exp_cpu) begin
      if (c_we) shadow[c_addr] = c_wd;
      else begin e.data = shadow[c_addr]; e.due = cyc + 1; cpu_q.push_back(e); end
    end
    if (exp_dbg) begin
      if (d_we) shadow[d_addr] = d_wd;
      else begin e.data = shadow[d_addr]; e.due = cyc + 1; dbg_q.push_back(e); end
    end
    @(negedge clk);
    check({tag, "/cpu_stall"}, 32'(cpu_stall), 32'(c_req & ~exp_cpu));
    check({tag, "/dbg_ready"}, 32'(dbg_ready), 32'(exp_dbg));
    check({tag, "/ram_en"}, 32'(ram_en), 32'(exp_cpu | exp_dbg));
    if (exp_cpu | exp_dbg) begin
      check({tag, "/ram_we"}, 32'(ram_we), 32'(exp_cpu ? c_we : d_we));
      check({tag, "/ram_addr"}, 32'(ram_addr), 32'(exp_cpu ? c_addr : d_addr));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    apply("idle", 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/cpu_stall"}, 32'(cpu_stall), 32'd0);
    check({tag, "/dbg_ready"}, 32'(dbg_ready), 32'd0);
    check({tag, "/cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    check({tag, "/dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
    check({tag, "/ram_en"}, 32'(ram_en), 32'd0);
    check({tag, "/ram_we"}, 32'(ram_we), 32'd0);
  endtask

  initial begin
    logic [13:0] ca;
    for (int i = 0; i < 16384; i++) shadow[i] = init_word(14'(i));

    // Reset with both requesters active: nothing may be granted.
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h10; cpu_wdata = '0;
    dbg_valid = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b1; dbg_addr = 14'h1; dbg_wdata = '0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // CPU load alone.
    apply("cpu_ld", 1'b1, 1'b0, 14'h10, 32'h0, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Sustained contention: four CPU grants then one forced debug grant.
    ca = 14'h20;
    for (int k = 0; k < 10; k++) begin
      logic g;
      g = ((k % 5) == 4);
      apply("starve", 1'b1, 1'b0, ca, 32'h0, 1'b1, 1'b0, 1'b0, 14'h100, 32'h0, !g, g);
      if (!g) ca = ca + 14'd1;
    end
    idle();

    // Bus lock for bulk loading.
    apply("lk_start", 1'b0, 1'b0, 14'h3, 32'h0, 1'b1, 1'b1, 1'b1, 14'h0, 32'hA0000000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      apply("lk_wr", 1'b1, 1'b0, 14'h3, 32'h0, 1'b1, 1'b1, 1'b1, 14'(i), 32'hC0DE0000 + 32'(i),
            1'b0, 1'b1);
    apply("lk_idle", 1'b1, 1'b0, 14'h3, 32'h0, 1'b0, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0);
    apply("lk_drop", 1'b1, 1'b0, 14'h3, 32'h0, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      apply("lk_rd", 1'b1, 1'b0, 14'(i), 32'h0, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Alternating CPU / debug reads, then write-then-read ordering.
    for (int i = 0; i < 4; i++) begin
      apply("il_cpu", 1'b1, 1'b0, 14'(5 + 2 * i), 32'h0, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0);
      apply("il_dbg", 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 1'b0, 14'(6 + 2 * i), 32'h0, 1'b0, 1'b1);
    end
    apply("wr_cpu", 1'b1, 1'b1, 14'h50, 32'h1234ABCD, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0);
    apply("rd_dbg", 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 1'b0, 14'h50, 32'h0, 1'b0, 1'b1);
    idle();

    // Forced grant carrying dbg_lock goes straight to LOCKED.
    for (int k = 0; k < 5; k++)
      apply("fl", 1'b1, 1'b0, 14'(k), 32'h0, 1'b1, 1'b1, 1'b1, 14'h40, 32'h5EED0040,
            k != 4, k == 4);
    apply("fl_lk", 1'b1, 1'b0, 14'h4, 32'h0, 1'b1, 1'b1, 1'b0, 14'h40, 32'h0, 1'b0, 1'b1);
    apply("fl_rel", 1'b1, 1'b0, 14'h4, 32'h0, 1'b1, 1'b0, 1'b0, 14'h41, 32'h0, 1'b1, 1'b0);
    idle();

    // Reset the cycle after a locked debug read: response dropped, lock released.
    apply("rs_lock", 1'b0, 1'b0, 14'h31, 32'h0, 1'b1, 1'b1, 1'b1, 14'h30, 32'hFACE0030, 1'b0, 1'b1);
    apply("rs_rd", 1'b1, 1'b0, 14'h31, 32'h0, 1'b1, 1'b1, 1'b0, 14'h30, 32'h0, 1'b0, 1'b1);
    rst = 1'b1;
    dbg_q.delete();
    cpu_q.delete();
    @(negedge clk);
    check_reset_outputs("rs_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    apply("rs_after", 1'b1, 1'b0, 14'h31, 32'h0, 1'b1, 1'b1, 1'b0, 14'h30, 32'h0, 1'b1, 1'b0);
    idle();
    idle();

    check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check("dbg_q_empty", 32'(dbg_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
